clock_time_controller: RTL and testbench
========================================

// Module: clock_time_controller
// PURPOSE
//   Sequences the seconds/minutes/hours bcd counter chain of the 7-segment clock.
//   Prescales clk_i to a 1 Hz seconds strobe and chains counter overflows into the next counter's increment.
//   Runs the RUN / SET_HR / SET_MIN button state machine for time setting, and drives digit blink enables.
//   Sits between the button inputs and the three bcd counter instances.
// PARAMETERS
//   PRESCALE      10000  clk_i cycles per seconds strobe (>=2)
//   BLINK_DIV     5000   clk_i cycles per blink phase in set modes (>=1)
//   REPEAT_DELAY  5000   hold cycles before first auto-repeat (HOLD_REPEAT_EN only)
//   REPEAT_RATE   1000   cycles between auto-repeats (HOLD_REPEAT_EN only)
// PORTS
//   clk_i         in   1  system clock, single domain
//   rst_i         in   1  asynchronous, active-high reset
//   mode_btn_i    in   1  mode button; already synchronised and debounced upstream
//   adj_btn_i     in   1  adjust button; already synchronised and debounced upstream
//   sec_ovf_i     in   1  overflow from seconds counter (already gated by its increment)
//   min_ovf_i     in   1  overflow from minutes counter
//   sec_inc_o     out  1  increment strobe to seconds counter
//   min_inc_o     out  1  increment strobe to minutes counter
//   hr_inc_o      out  1  increment strobe to hours counter
//   sec_clr_o     out  1  reset strobe to seconds counter
//   mode_o        out  2  current state: 0=RUN 1=SET_HR 2=SET_MIN
//   hr_disp_en_o  out  1  hours digits visible
//   min_disp_en_o out  1  minutes digits visible
// BEHAVIOUR
//   Reset values: state RUN; prescaler, blink and repeat counters 0; blink phase 1.
//     Outputs at reset: mode_o=0, all strobes 0, both disp_en=1.
//   Edge detect: press = btn & ~btn_q. btn_q resets to 1, so a button held through reset is not a press.
//   FSM (registered, takes effect next cycle): a mode press steps RUN->SET_HR->SET_MIN->RUN.
//     Encoding 3 is illegal and recovers to RUN.
//   Prescaler: in RUN, counts 0..PRESCALE-1 and wraps.
//     sec_inc_o = (state==RUN) && cnt==PRESCALE-1, combinational.
//     First pulse is PRESCALE-1 edges after reset release; then one pulse every PRESCALE cycles.
//     In SET states the prescaler is held at 0 and sec_inc_o=0.
//   Chaining: RUN passes min_inc_o=sec_ovf_i and hr_inc_o=min_ovf_i combinationally (no added latency).
//   SET_HR: hr_inc_o = adj press; min_inc_o=0; min_ovf_i ignored.
//   SET_MIN: min_inc_o = adj press; hr_inc_o=0, so no carry into hours while setting.
//   In RUN an adj press is ignored.
//   SET_MIN->RUN transition: sec_clr_o is high for exactly one cycle, the cycle after the mode press.
//     The prescaler also restarts from 0.
//   Simultaneous mode press and adj press: the mode transition wins and the adj press is dropped.
//   Blink: on entry to a SET state, phase=1 and the blink counter=0. The phase toggles every BLINK_DIV cycles.
//     SET_HR: hr_disp_en_o=phase; SET_MIN: min_disp_en_o=phase. All other disp_en outputs are 1.
//   Reset asserted mid-operation: all state clears asynchronously; strobes drop in the same cycle.
// CONFIGURATION
//   HOLD_REPEAT_EN defined: in SET states, adj held continuously gives extra adj pulses.
//     First extra pulse REPEAT_DELAY cycles after the press, then every REPEAT_RATE cycles while held.
//     Releasing the button or changing state clears the repeat counter.
//   HOLD_REPEAT_EN undefined: one pulse per rising edge only; REPEAT_* parameters unused.
// TESTING (PRESCALE=4, BLINK_DIV=2, REPEAT_DELAY=6, REPEAT_RATE=3)
//   Release reset, run 12 cycles -> sec_inc_o high at cycles 3,7,11; mode_o=0; both disp_en=1.
//   RUN, sec_ovf_i=1 for 1 cycle -> min_inc_o=1 in that cycle; same for min_ovf_i -> hr_inc_o.
//   Mode press -> mode_o=1; adj press -> one 1-cycle hr_inc_o; sec_inc_o stays 0; hr_disp_en toggles every 2 cycles.
//   Three mode presses -> mode_o 1,2,0; sec_clr_o one pulse on 2->0; next sec_inc_o 3 cycles later.
//   SET_HR, mode and adj pressed in same cycle -> mode_o=2; hr_inc_o=0 and min_inc_o=0 throughout.
//   HOLD_REPEAT_EN, SET_MIN, adj held 14 cycles from t0 -> min_inc_o at t0, t0+6, t0+9, t0+12; undefined: t0 only.

Source files
------------

// File: rtl/clock_time_controller.sv
// Seconds prescaler, counter chaining and RUN/SET_HR/SET_MIN button FSM.
// Optional HOLD_REPEAT_EN macro adds auto-repeat on a held adjust button.
module clock_time_controller #(
  parameter int PRESCALE     = 10000,
  parameter int BLINK_DIV    = 5000,
  parameter int REPEAT_DELAY = 5000,
  parameter int REPEAT_RATE  = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       mode_btn_i,
  input  logic       adj_btn_i,
  input  logic       sec_ovf_i,
  input  logic       min_ovf_i,
  output logic       sec_inc_o,
  output logic       min_inc_o,
  output logic       hr_inc_o,
  output logic       sec_clr_o,
  output logic [1:0] mode_o,
  output logic       hr_disp_en_o,
  output logic       min_disp_en_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    BAD     = 2'd3
  } state_t;

  localparam int PW = $clog2(PRESCALE);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] P_MAX = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);

  state_t          state_q;
  logic [PW-1:0]   pre_q;
  logic [BW-1:0]   blk_q;
  logic            phase_q;
  logic            mode_q;
  logic            adj_q;
  logic            sec_clr_q;
  logic            mode_press;
  logic            adj_press;
  logic            adj_evt;
  logic            run;
  logic            in_set;

  assign mode_press = mode_btn_i & ~mode_q;
  assign adj_press  = adj_btn_i & ~adj_q;
  assign run        = (state_q == RUN);
  assign in_set     = (state_q == SET_HR) | (state_q == SET_MIN);

`ifdef HOLD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [RW-1:0] R_HIT = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_TOP = RW'(REPEAT_DELAY + REPEAT_RATE - 1);

  logic [RW-1:0] rpt_q;
  logic          hold;

  assign hold = in_set & adj_btn_i & ~mode_press;

  // After the first repeat, wrap back so hits recur every REPEAT_RATE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rpt_q <= '0;
    end else if (!hold) begin
      rpt_q <= '0;
    end else if (rpt_q == R_TOP) begin
      rpt_q <= R_HIT;
    end else begin
      rpt_q <= rpt_q + 1'b1;
    end
  end

  assign adj_evt = adj_press | (hold & (rpt_q == R_HIT));
`else
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE};
  assign adj_evt    = adj_press;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      mode_q    <= 1'b1;
      adj_q     <= 1'b1;
      sec_clr_q <= 1'b0;
    end else begin
      mode_q    <= mode_btn_i;
      adj_q     <= adj_btn_i;
      sec_clr_q <= (state_q == SET_MIN) & mode_press;
      unique case (state_q)
        RUN:     if (mode_press) state_q <= SET_HR;
        SET_HR:  if (mode_press) state_q <= SET_MIN;
        SET_MIN: if (mode_press) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q <= '0;
    end else if (!run || pre_q == P_MAX) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Mode press restarts the blink so a new SET state starts visible
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blk_q   <= '0;
      phase_q <= 1'b1;
    end else if (mode_press || !in_set) begin
      blk_q   <= '0;
      phase_q <= 1'b1;
    end else if (blk_q == B_MAX) begin
      blk_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      blk_q   <= blk_q + 1'b1;
    end
  end

  assign sec_inc_o = ~rst_i & run & (pre_q == P_MAX);

  assign min_inc_o = ~rst_i & (run ? sec_ovf_i :
    (state_q == SET_MIN) & adj_evt & ~mode_press);

  assign hr_inc_o = ~rst_i & (run ? min_ovf_i :
    (state_q == SET_HR) & adj_evt & ~mode_press);

  assign sec_clr_o     = sec_clr_q;
  assign mode_o        = state_q;
  assign hr_disp_en_o  = (state_q == SET_HR) ? phase_q : 1'b1;
  assign min_disp_en_o = (state_q == SET_MIN) ? phase_q : 1'b1;

endmodule

// File: tb/tb_clock_time_controller.sv
// Scoreboard bench for clock_time_controller with small test parameters.
// Expected vectors: {sec_inc,min_inc,hr_inc,sec_clr,mode[1:0],hr_en,min_en}.
module tb_clock_time_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_btn, adj_btn, sec_ovf, min_ovf;
  logic       sec_inc, min_inc, hr_inc, sec_clr;
  logic [1:0] mode;
  logic       hr_en, min_en;

  typedef struct {
    logic [7:0] exp;
    string      nm;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad   = 0;
  bit    rep;

  always #5 clk = ~clk;

  clock_time_controller #(
    .PRESCALE    (4),
    .BLINK_DIV   (2),
    .REPEAT_DELAY(6),
    .REPEAT_RATE (3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mode_btn_i   (mode_btn),
    .adj_btn_i    (adj_btn),
    .sec_ovf_i    (sec_ovf),
    .min_ovf_i    (min_ovf),
    .sec_inc_o    (sec_inc),
    .min_inc_o    (min_inc),
    .hr_inc_o     (hr_inc),
    .sec_clr_o    (sec_clr),
    .mode_o       (mode),
    .hr_disp_en_o (hr_en),
    .min_disp_en_o(min_en)
  );

  function automatic logic [7:0] v(
    input logic si, mi, hi, sc,
    input logic [1:0] md,
    input logic he, me
  );
    return {si, mi, hi, sc, md, he, me};
  endfunction

  task automatic cyc(
    input logic r, mb, ab, so, mo,
    input logic [7:0] e,
    input string nm
  );
    item_t it;
    @(posedge clk);
    #1;
    rst      = r;
    mode_btn = mb;
    adj_btn  = ab;
    sec_ovf  = so;
    min_ovf  = mo;
    it.exp   = e;
    it.nm    = nm;
    q.push_back(it);
  endtask

  // Monitor: compares one expected vector per cycle on the falling edge
  initial begin
    item_t it;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it  = q.pop_front();
        act = {sec_inc, min_inc, hr_inc, sec_clr, mode, hr_en, min_en};
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s: got %b want %b", it.nm, act, it.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef HOLD_REPEAT_EN
    rep = 1'b1;
`else
    rep = 1'b0;
`endif
    rst = 1'b1;
    mode_btn = 1'b1;
    adj_btn = 1'b0;
    sec_ovf = 1'b1;
    min_ovf = 1'b1;

    for (int i = 0; i < 2; i++)
      cyc(1, 1, 0, 1, 1, v(0, 0, 0, 0, 0, 1, 1), "reset");

    for (int i = 0; i < 16; i++)
      cyc(0, i == 0, i == 5, i == 12, i == 13,
          v(i % 4 == 3, i == 12, i == 13, 0, 0, 1, 1),
          $sformatf("run c%0d", i));

    cyc(0, 1, 0, 0, 0, v(0, 0, 0, 0, 0, 1, 1), "press c16");

    for (int i = 17; i < 25; i++)
      cyc(0, 0, i == 19 || i == 20, i == 23, i == 22,
          v(0, 0, i == 19, 0, 1, ((i - 17) / 2) % 2 == 0, 1),
          $sformatf("set_hr c%0d", i));

    cyc(0, 1, 1, 0, 0, v(0, 0, 0, 0, 1, 1, 1), "mode+adj c25");

    for (int i = 26; i < 43; i++)
      cyc(0, 0, i >= 28 && i <= 41, 0, i == 30,
          v(0,
            i == 28 || (rep && (i == 34 || i == 37 || i == 40)),
            0, 0, 2, 1, ((i - 26) / 2) % 2 == 0),
          $sformatf("set_min c%0d", i));

    cyc(0, 1, 0, 0, 0, v(0, 0, 0, 0, 2, 1, 1), "press c43");

    for (int i = 44; i < 48; i++)
      cyc(0, 0, 0, 0, 0, v(i == 47, 0, 0, i == 44, 0, 1, 1),
          $sformatf("back_run c%0d", i));

    cyc(0, 1, 0, 0, 0, v(0, 0, 0, 0, 0, 1, 1), "press c48");
    cyc(0, 0, 0, 0, 0, v(0, 0, 0, 0, 1, 1, 1), "set_hr c49");
    cyc(1, 0, 0, 1, 1, v(0, 0, 0, 0, 0, 1, 1), "async rst c50");
    cyc(1, 0, 0, 1, 1, v(0, 0, 0, 0, 0, 1, 1), "async rst c51");

    for (int k = 0; k < 4; k++)
      cyc(0, 0, 0, 0, 0, v(k == 3, 0, 0, 0, 0, 1, 1),
          $sformatf("rerun c%0d", k));

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
